uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart_tx serializer among four byte requesters.
// A grant is held until a REQ_LAST byte completes or the owner stalls for HoldTimeout cycles.
module uart_tx_arbiter #(
   parameter int unsigned HoldTimeout = 2500
) (
   input  logic        ser_clk_i,
   input  logic        rst_ni,
   input  logic [3:0]  req_valid_i,
   input  logic [31:0] req_byte_i,
   input  logic [3:0]  req_last_i,
   output logic [3:0]  req_ready_o,
   output logic        tx_dv_o,
   output logic [7:0]  tx_byte_o,
   input  logic        tx_done_i,
   output logic [3:0]  grant_o,
   output logic        busy_o,
   output logic        drop_o
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StWait = 2'd2
   } state_e;

   localparam logic [15:0] StallLimit = 16'(HoldTimeout - 1);

   state_e      state_q, state_d;
   logic [3:0]  grant_q, grant_d;
   logic [1:0]  owner_q, owner_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [15:0] stall_q, stall_d;
   logic        last_q, last_d;
   logic        tx_dv_q, tx_dv_d;
   logic [7:0]  tx_byte_q, tx_byte_d;
   logic        busy_q, busy_d;
   logic        drop_q, drop_d;

   logic        pick_found;
   logic [1:0]  pick_idx;
   logic [1:0]  cand;
   logic        transfer;
   logic [7:0]  owner_byte;

   // First valid requester scanning upward from the round-robin pointer.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = ptr_q;
      cand       = ptr_q;
      for (int k = 0; k < 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!pick_found && req_valid_i[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign transfer   = (state_q == StSend) && req_valid_i[owner_q];
   assign owner_byte = req_byte_i[{owner_q, 3'b000} +: 8];

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      stall_d   = stall_q;
      last_d    = last_q;
      tx_dv_d   = 1'b0;
      tx_byte_d = tx_byte_q;
      drop_d    = 1'b0;

      case (state_q)
         StIdle: begin
            grant_d = 4'b0000;
            if (pick_found) begin
               grant_d = 4'b0001 << pick_idx;
               owner_d = pick_idx;
               stall_d = 16'd0;
               state_d = StSend;
            end
         end
         StSend: begin
            if (transfer) begin
               tx_byte_d = owner_byte;
               tx_dv_d   = 1'b1;
               last_d    = req_last_i[owner_q];
               stall_d   = 16'd0;
               state_d   = StWait;
            end else if (stall_q == StallLimit) begin
               // No transfer here already implies the owner's valid is low.
               drop_d  = 1'b1;
               ptr_d   = owner_q + 2'd1;
               grant_d = 4'b0000;
               stall_d = 16'd0;
               state_d = StIdle;
            end else if (stall_q != 16'hffff) begin
               stall_d = stall_q + 16'd1;
            end
         end
         StWait: begin
            if (tx_done_i) begin
               if (last_q) begin
                  ptr_d   = owner_q + 2'd1;
                  grant_d = 4'b0000;
                  state_d = StIdle;
               end else begin
                  state_d = StSend;
               end
            end
         end
         default: begin
            grant_d = 4'b0000;
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge ser_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         grant_q   <= 4'b0000;
         owner_q   <= 2'd0;
         ptr_q     <= 2'd0;
         stall_q   <= 16'd0;
         last_q    <= 1'b0;
         tx_dv_q   <= 1'b0;
         tx_byte_q <= 8'h00;
         busy_q    <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         stall_q   <= stall_d;
         last_q    <= last_d;
         tx_dv_q   <= tx_dv_d;
         tx_byte_q <= tx_byte_d;
         busy_q    <= busy_d;
         drop_q    <= drop_d;
      end
   end

   assign req_ready_o = (state_q == StSend) ? grant_q : 4'b0000;
   assign tx_dv_o     = tx_dv_q;
   assign tx_byte_o   = tx_byte_q;
   assign grant_o     = grant_q;
   assign busy_o      = busy_q;
   assign drop_o      = drop_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter; outputs checked 1 time unit after each edge.
module tb_uart_tx_arbiter;

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [31:0] bytes;
      logic [3:0]  last;
      logic        done;
      logic [18:0] exp;   // {grant, ready, dv, byte, busy, drop}
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic [3:0]  req_valid = 4'b0;
   logic [31:0] req_byte = 32'h0;
   logic [3:0]  req_last = 4'b0;
   logic        tx_done = 1'b0;
   logic [3:0]  req_ready;
   logic        tx_dv;
   logic [7:0]  tx_byte;
   logic [3:0]  grant;
   logic        busy;
   logic        drop;

   int n_vec = 0;
   int n_bad = 0;
   vec_t tbl_a[$];
   vec_t tbl_b[$];

   uart_tx_arbiter #(.HoldTimeout(4)) dut (
      .ser_clk_i  (clk),
      .rst_ni     (rst_ni),
      .req_valid_i(req_valid),
      .req_byte_i (req_byte),
      .req_last_i (req_last),
      .req_ready_o(req_ready),
      .tx_dv_o    (tx_dv),
      .tx_byte_o  (tx_byte),
      .tx_done_i  (tx_done),
      .grant_o    (grant),
      .busy_o     (busy),
      .drop_o     (drop)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic rst, logic [3:0] v, logic [31:0] b, logic [3:0] l, logic d,
                               logic [3:0] g, logic [3:0] r, logic dv, logic [7:0] byt,
                               logic bsy, logic drp);
      vec_t x;
      x.rst   = rst;
      x.valid = v;
      x.bytes = b;
      x.last  = l;
      x.done  = d;
      x.exp   = {g, r, dv, byt, bsy, drp};
      return x;
   endfunction

   task automatic check(input string name, input logic [18:0] exp);
      logic [18:0] got;
      got = {grant, req_ready, tx_dv, tx_byte, busy, drop};
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got grant=%b ready=%b dv=%b byte=%h busy=%b drop=%b, want grant=%b ready=%b dv=%b byte=%h busy=%b drop=%b",
                  name, got[18:15], got[14:11], got[10], got[9:2], got[1], got[0],
                  exp[18:15], exp[14:11], exp[10], exp[9:2], exp[1], exp[0]);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      @(negedge clk);
      rst_ni    = !v.rst;
      req_valid = v.valid;
      req_byte  = v.bytes;
      req_last  = v.last;
      tx_done   = v.done;
      @(posedge clk);
      #1;
      check(name, v.exp);
   endtask

   initial begin
      logic [31:0] allb;
      logic [7:0]  prev;
      int          order[5];
      allb  = 32'h4332_2110;
      order = '{0, 1, 2, 3, 0};

      // Single requester 1, one-byte packet.
      tbl_a.push_back(mk(1, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
      tbl_a.push_back(mk(0, 4'b0010, 32'h0000_a500, 4'b0010, 0, 4'b0010, 4'b0010, 0, 8'h00, 1, 0));
      tbl_a.push_back(mk(0, 4'b0010, 32'h0000_a500, 4'b0010, 0, 4'b0010, 4'b0000, 1, 8'ha5, 1, 0));
      tbl_a.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0010, 4'b0000, 0, 8'ha5, 1, 0));
      tbl_a.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'ha5, 0, 0));
      // Requesters 0 and 2; 0 sends a 3-byte packet uninterrupted.
      tbl_a.push_back(mk(1, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
      tbl_a.push_back(mk(0, 4'b0101, 32'h0077_0011, 4'b0100, 0, 4'b0001, 4'b0001, 0, 8'h00, 1, 0));
      tbl_a.push_back(mk(0, 4'b0101, 32'h0077_0011, 4'b0100, 0, 4'b0001, 4'b0000, 1, 8'h11, 1, 0));
      tbl_a.push_back(mk(0, 4'b0101, 32'h0077_0022, 4'b0100, 0, 4'b0001, 4'b0000, 0, 8'h11, 1, 0));
      tbl_a.push_back(mk(0, 4'b0101, 32'h0077_0022, 4'b0100, 1, 4'b0001, 4'b0001, 0, 8'h11, 1, 0));
      tbl_a.push_back(mk(0, 4'b0101, 32'h0077_0022, 4'b0100, 0, 4'b0001, 4'b0000, 1, 8'h22, 1, 0));
      tbl_a.push_back(mk(0, 4'b0101, 32'h0077_0033, 4'b0101, 1, 4'b0001, 4'b0001, 0, 8'h22, 1, 0));
      tbl_a.push_back(mk(0, 4'b0101, 32'h0077_0033, 4'b0101, 0, 4'b0001, 4'b0000, 1, 8'h33, 1, 0));
      tbl_a.push_back(mk(0, 4'b0100, 32'h0077_0033, 4'b0101, 1, 4'b0000, 4'b0000, 0, 8'h33, 0, 0));
      tbl_a.push_back(mk(0, 4'b0100, 32'h0077_0000, 4'b0100, 0, 4'b0100, 4'b0100, 0, 8'h33, 1, 0));
      tbl_a.push_back(mk(0, 4'b0100, 32'h0077_0000, 4'b0100, 0, 4'b0100, 4'b0000, 1, 8'h77, 1, 0));
      tbl_a.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h77, 0, 0));
      // Pointer now 3: requester 3 wins with all valid, then goes into WAIT mid-packet.
      tbl_a.push_back(mk(0, 4'b1111, allb, 4'b1111, 0, 4'b1000, 4'b1000, 0, 8'h77, 1, 0));
      tbl_a.push_back(mk(0, 4'b1111, allb, 4'b0000, 0, 4'b1000, 4'b0000, 1, 8'h43, 1, 0));

      // All four contend with one-byte packets; done pulses in IDLE must be ignored.
      tbl_b.push_back(mk(1, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
      prev = 8'h00;
      for (int i = 0; i < 5; i++) begin
         logic [3:0] oh;
         logic [7:0] bk;
         oh = 4'(1 << order[i]);
         bk = allb[8*order[i] +: 8];
         tbl_b.push_back(mk(0, 4'b1111, allb, 4'b1111, (i > 0), oh, oh, 0, prev, 1, 0));
         tbl_b.push_back(mk(0, 4'b1111, allb, 4'b1111, 0, oh, 4'b0000, 1, bk, 1, 0));
         tbl_b.push_back(mk(0, 4'b1111, allb, 4'b1111, 1, 4'b0000, 4'b0000, 0, bk, 0, 0));
         prev = bk;
      end
      // Requester 3 sends a non-last byte then stalls until the timeout fires.
      tbl_b.push_back(mk(0, 4'b1000, 32'h0100_0000, 4'b0000, 0, 4'b1000, 4'b1000, 0, 8'h10, 1, 0));
      tbl_b.push_back(mk(0, 4'b1000, 32'h0100_0000, 4'b0000, 0, 4'b1000, 4'b0000, 1, 8'h01, 1, 0));
      tbl_b.push_back(mk(0, 4'b0000, 32'h0100_0000, 4'b0000, 1, 4'b1000, 4'b1000, 0, 8'h01, 1, 0));
      tbl_b.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 1, 4'b1000, 4'b1000, 0, 8'h01, 1, 0));
      tbl_b.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b1000, 4'b1000, 0, 8'h01, 1, 0));
      tbl_b.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 1, 4'b1000, 4'b1000, 0, 8'h01, 1, 0));
      tbl_b.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h01, 0, 1));
      tbl_b.push_back(mk(0, 4'b0000, 32'h0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h01, 0, 0));
      tbl_b.push_back(mk(0, 4'b1111, allb, 4'b0000, 0, 4'b0001, 4'b0001, 0, 8'h01, 1, 0));

      foreach (tbl_a[i]) apply(tbl_a[i], $sformatf("tbl_a[%0d]", i));

      // Reset asserted mid-packet while in WAIT: outputs clear without waiting for an edge.
      @(negedge clk);
      rst_ni  = 1'b0;
      tx_done = 1'b0;
      #1;
      check("rst_async", 19'h0);
      @(posedge clk);
      @(negedge clk);
      rst_ni    = 1'b1;
      req_valid = 4'b0000;
      tx_done   = 1'b1;
      @(posedge clk);
      #1;
      check("stale_done_after_rst", 19'h0);
      @(negedge clk);
      tx_done   = 1'b0;
      req_valid = 4'b1111;
      @(posedge clk);
      #1;
      check("ptr_after_rst", {4'b0001, 4'b0001, 1'b0, 8'h00, 1'b1, 1'b0});

      foreach (tbl_b[i]) apply(tbl_b[i], $sformatf("tbl_b[%0d]", i));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
